// File: rtl/acq_defs_pkg.sv
// Shared definitions for the A-line acquisition controller: FSM state
// encodings, counter widths, default geometry and a bank mask helper.
package acq_defs;

   localparam int ADDR_W  = 11;
   localparam int ALINE_W = 10;

   localparam logic [ADDR_W-1:0]  NSAMPLES_DEF = 11'd1170;
   localparam logic [ALINE_W-1:0] NALINES_DEF  = 10'd512;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_ACQ       = 3'd2,
      ST_WAIT_BANK = 3'd3,
      ST_DELAY     = 3'd4
   } acq_state_e;

   // One-hot mask selecting bank 'sel' in a two-bank vector
   function automatic logic [1:0] bank_mask(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/aline_acq_controller_bank_handshake.sv
// Ping-pong bank ownership: bank_ready/bank_sel flops, set-over-ack
// precedence, and the "next bank still owned by readout" flag for the FSM.
module bank_handshake
   import acq_defs::*;
(
   input  logic       i_clock,
   input  logic       i_sclr,
   input  logic       i_set_full,
   input  logic [1:0] i_rd_ack,
   output logic       o_bank_sel,
   output logic [1:0] o_bank_ready,
   output logic       o_next_busy
);

   logic       r_bank_sel;
   logic [1:0] r_bank_ready;
   logic       w_other;
   logic [1:0] w_set_mask;

   assign w_other    = ~r_bank_sel;
   assign w_set_mask = i_set_full ? bank_mask(r_bank_sel) : 2'b00;

   // Ownership flops: ack clears, a bank fill sets (set wins) and flips the write bank
   always_ff @(posedge i_clock or posedge i_sclr) begin
      if (i_sclr) begin
         r_bank_sel   <= 1'b0;
         r_bank_ready <= 2'b00;
      end else begin
         r_bank_ready <= (r_bank_ready & ~i_rd_ack) | w_set_mask;
         if (i_set_full) begin
            r_bank_sel <= ~r_bank_sel;
         end else begin
            r_bank_sel <= r_bank_sel;
         end
      end
   end

   // The bank we switch to on a fill is busy unless readout acks it this cycle
   assign o_next_busy  = r_bank_ready[w_other] & ~i_rd_ack[w_other];
   assign o_bank_sel   = r_bank_sel;
   assign o_bank_ready = r_bank_ready;

endmodule

// File: rtl/aline_acq_controller.sv
// Trigger-aligned, frame-aware sample acquisition sequencer.
// Optional build macro ACQ_TRIG_DELAY_EN adds a programmable trigger-to-
// first-sample delay (TRIG_DELAY clocks) via an extra DELAY state.
module aline_acq_controller
   import acq_defs::*;
#(
   parameter logic [ADDR_W-1:0]  NSAMPLES = NSAMPLES_DEF,
   parameter logic [ALINE_W-1:0] NALINES  = NALINES_DEF
`ifdef ACQ_TRIG_DELAY_EN
   ,parameter logic [7:0]        TRIG_DELAY = 8'd0
`endif
) (
   input  logic               clock,
   input  logic               sclr,
   input  logic               enable,
   input  logic               trig,
   input  logic [1:0]         rd_ack,
   output logic [ADDR_W-1:0]  sample_addr,
   output logic               sample_we,
   output logic               bank_sel,
   output logic [ALINE_W-1:0] aline_idx,
   output logic [1:0]         bank_ready,
   output logic               frame_done,
   output logic               overflow,
   output logic               busy
);

   localparam logic [ADDR_W-1:0]  LAST_ADDR  = NSAMPLES - 11'd1;
   localparam logic [ALINE_W-1:0] LAST_ALINE = NALINES - 10'd1;

   acq_state_e         r_state;
   logic               r_trig_q;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_we;
   logic [ALINE_W-1:0] r_aline;
   logic               r_frame_done;
   logic               r_overflow;
`ifdef ACQ_TRIG_DELAY_EN
   logic [7:0]         r_dly;
`endif

   logic w_rise;
   logic w_line_end;
   logic w_set_full;
   logic w_next_busy;
   logic w_bank_sel;

   assign w_rise     = trig & ~r_trig_q;
   assign w_line_end = (r_state == ST_ACQ) && (r_addr == LAST_ADDR);
   assign w_set_full = w_line_end && (r_aline == LAST_ALINE);

   bank_handshake u_bank (
      .i_clock      (clock),
      .i_sclr       (sclr),
      .i_set_full   (w_set_full),
      .i_rd_ack     (rd_ack),
      .o_bank_sel   (w_bank_sel),
      .o_bank_ready (bank_ready),
      .o_next_busy  (w_next_busy)
   );

   // Acquisition FSM with address/A-line counters and registered status outputs
   always_ff @(posedge clock or posedge sclr) begin
      if (sclr) begin
         r_state      <= ST_IDLE;
         r_trig_q     <= 1'b0;
         r_addr       <= 11'd0;
         r_we         <= 1'b0;
         r_aline      <= 10'd0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
`ifdef ACQ_TRIG_DELAY_EN
         r_dly        <= 8'd0;
`endif
      end else begin
         r_trig_q     <= trig;
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_state <= enable ? ST_ARMED : ST_IDLE;
            end
            ST_ARMED: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
               end else if (w_rise) begin
`ifdef ACQ_TRIG_DELAY_EN
                  if (TRIG_DELAY == 8'd0) begin
                     r_state <= ST_ACQ;
                     r_addr  <= 11'd0;
                     r_we    <= 1'b1;
                  end else begin
                     r_dly   <= TRIG_DELAY;
                     r_state <= ST_DELAY;
                  end
`else
                  r_state <= ST_ACQ;
                  r_addr  <= 11'd0;
                  r_we    <= 1'b1;
`endif
               end else begin
                  r_state <= ST_ARMED;
               end
            end
            ST_ACQ: begin
               if (w_line_end) begin
                  r_addr <= 11'd0;
                  r_we   <= 1'b0;
                  if (w_set_full) begin
                     r_aline      <= 10'd0;
                     r_frame_done <= 1'b1;
                     if (w_next_busy) begin
                        r_state <= ST_WAIT_BANK;
                     end else begin
                        r_state <= enable ? ST_ARMED : ST_IDLE;
                     end
                  end else begin
                     r_aline <= r_aline + 10'd1;
                     r_state <= enable ? ST_ARMED : ST_IDLE;
                  end
               end else begin
                  r_addr <= r_addr + 11'd1;
               end
            end
            ST_WAIT_BANK: begin
               if (w_rise) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_overflow <= r_overflow;
               end
               if (rd_ack[w_bank_sel]) begin
                  r_state <= enable ? ST_ARMED : ST_IDLE;
               end else begin
                  r_state <= ST_WAIT_BANK;
               end
            end
`ifdef ACQ_TRIG_DELAY_EN
            ST_DELAY: begin
               if (!enable) begin
                  r_state <= ST_IDLE;
               end else if (r_dly == 8'd1) begin
                  r_state <= ST_ACQ;
                  r_addr  <= 11'd0;
                  r_we    <= 1'b1;
               end else begin
                  r_dly <= r_dly - 8'd1;
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
               r_we    <= 1'b0;
            end
         endcase
      end
   end

   assign sample_addr = r_addr;
   assign sample_we   = r_we;
   assign bank_sel    = w_bank_sel;
   assign aline_idx   = r_aline;
   assign frame_done  = r_frame_done;
   assign overflow    = r_overflow;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aline_acq_controller.sv
// Scoreboard bench for aline_acq_controller (NSAMPLES=8, NALINES=2).
// Honours ACQ_TRIG_DELAY_EN: with it defined the DUT gets TRIG_DELAY=3.
module tb_aline_acq_controller;

   localparam logic [10:0] NS = 11'd8;
   localparam logic [9:0]  NA = 10'd2;
`ifdef ACQ_TRIG_DELAY_EN
   localparam int TB_DLY = 3;
`else
   localparam int TB_DLY = 0;
`endif

   logic        clock;
   logic        sclr;
   logic        enable;
   logic        trig;
   logic [1:0]  rd_ack;
   logic [10:0] sample_addr;
   logic        sample_we;
   logic        bank_sel;
   logic [9:0]  aline_idx;
   logic [1:0]  bank_ready;
   logic        frame_done;
   logic        overflow;
   logic        busy;

   typedef struct {
      logic        is_frame;
      logic [10:0] addr;
      logic        bank;
      logic [9:0]  aline;
      logic [1:0]  ready;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

`ifdef ACQ_TRIG_DELAY_EN
   aline_acq_controller #(.NSAMPLES(NS), .NALINES(NA), .TRIG_DELAY(8'd3)) dut (
`else
   aline_acq_controller #(.NSAMPLES(NS), .NALINES(NA)) dut (
`endif
      .clock       (clock),
      .sclr        (sclr),
      .enable      (enable),
      .trig        (trig),
      .rd_ack      (rd_ack),
      .sample_addr (sample_addr),
      .sample_we   (sample_we),
      .bank_sel    (bank_sel),
      .aline_idx   (aline_idx),
      .bank_ready  (bank_ready),
      .frame_done  (frame_done),
      .overflow    (overflow),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every write beat and every frame_done pulse must match the queue head
   always @(negedge clock) begin
      if (!sclr && (sample_we || frame_done)) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: we=%0b fd=%0b addr=%0d bank=%0b expected no output",
                     sample_we, frame_done, sample_addr, bank_sel);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.is_frame) begin
               check("frame_done", {31'd0, frame_done}, 32'd1);
               check("frame_ready", {30'd0, bank_ready}, {30'd0, e.ready});
               check("frame_bank_sel", {31'd0, bank_sel}, {31'd0, e.bank});
               check("frame_aline", {22'd0, aline_idx}, {22'd0, e.aline});
            end else begin
               check("wr_we", {31'd0, sample_we}, 32'd1);
               check("wr_addr", {21'd0, sample_addr}, {21'd0, e.addr});
               check("wr_bank", {31'd0, bank_sel}, {31'd0, e.bank});
               check("wr_aline", {22'd0, aline_idx}, {22'd0, e.aline});
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic push_aline(input logic bank, input logic [9:0] aline, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.is_frame = 1'b0;
         e.addr     = 11'(i);
         e.bank     = bank;
         e.aline    = aline;
         e.ready    = 2'b00;
         q.push_back(e);
      end
   endtask

   task automatic push_frame(input logic [1:0] ready, input logic sel);
      exp_t e;
      e.is_frame = 1'b1;
      e.addr     = 11'd0;
      e.bank     = sel;
      e.aline    = 10'd0;
      e.ready    = ready;
      q.push_back(e);
   endtask

   task automatic pulse_trig();
      @(negedge clock);
      trig = 1'b1;
      @(negedge clock);
      trig = 1'b0;
   endtask

   task automatic pulse_ack(input logic [1:0] a);
      @(negedge clock);
      rd_ack = a;
      @(negedge clock);
      rd_ack = 2'b00;
   endtask

   task automatic wait_addr(input logic [10:0] v);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (sample_we && sample_addr == v) begin
            found = 1'b1;
            break;
         end
      end
      check("wait_addr_found", {31'd0, found}, 32'd1);
   endtask

   localparam int LINE_WAIT = 8 + TB_DLY + 4;

   initial begin
      int lat;
      sclr   = 1'b1;
      enable = 1'b0;
      trig   = 1'b0;
      rd_ack = 2'b00;
      tick(2);
      check("rst_addr", {21'd0, sample_addr}, 32'd0);
      check("rst_we", {31'd0, sample_we}, 32'd0);
      check("rst_ready", {30'd0, bank_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      sclr = 1'b0;
      tick(1);
      enable = 1'b1;
      tick(2);
      check("armed_busy", {31'd0, busy}, 32'd1);

      // A-line 0 of bank 0, with first-sample latency measurement
      push_aline(1'b0, 10'd0, 8);
      trig = 1'b1;
      lat  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         lat++;
         if (lat == 1) trig = 1'b0;
         if (sample_we) break;
      end
      trig = 1'b0;
      check("first_we_latency", lat, 1 + TB_DLY);
      tick(LINE_WAIT);
      check("line0_aline_idx", {22'd0, aline_idx}, 32'd1);
      check("line0_we_low", {31'd0, sample_we}, 32'd0);

      // A-line 1 fills bank 0; extra trigger mid-line is ignored
      push_aline(1'b0, 10'd1, 8);
      push_frame(2'b01, 1'b1);
      pulse_trig();
      wait_addr(11'd3);
      trig = 1'b1;
      @(negedge clock);
      trig = 1'b0;
      tick(LINE_WAIT);
      check("fill0_overflow", {31'd0, overflow}, 32'd0);
      check("fill0_ready", {30'd0, bank_ready}, 32'd1);
      check("fill0_bank_sel", {31'd0, bank_sel}, 32'd1);
      check("fill0_aline", {22'd0, aline_idx}, 32'd0);

      // Fill bank 1 with no acks -> WAIT_BANK
      push_aline(1'b1, 10'd0, 8);
      pulse_trig();
      tick(LINE_WAIT);
      push_aline(1'b1, 10'd1, 8);
      push_frame(2'b11, 1'b0);
      pulse_trig();
      tick(LINE_WAIT);
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("wait_overflow_pre", {31'd0, overflow}, 32'd0);

      // Dropped trigger sets sticky overflow with no writes
      pulse_trig();
      tick(LINE_WAIT);
      check("overflow_set", {31'd0, overflow}, 32'd1);
      pulse_ack(2'b01);
      check("ack0_ready", {30'd0, bank_ready}, 32'd2);
      push_aline(1'b0, 10'd0, 8);
      pulse_trig();
      tick(LINE_WAIT);
      check("after_wait_aline", {22'd0, aline_idx}, 32'd1);
      check("overflow_sticky", {31'd0, overflow}, 32'd1);

      // Ack of a bank that is not ready is ignored; valid ack clears
      pulse_ack(2'b01);
      check("ack_not_ready", {30'd0, bank_ready}, 32'd2);
      pulse_ack(2'b10);
      check("ack1_ready", {30'd0, bank_ready}, 32'd0);

      // Async reset mid-A-line
      push_aline(1'b0, 10'd1, 6);
      pulse_trig();
      wait_addr(11'd5);
      #1 sclr = 1'b1;
      #1;
      check("mid_rst_addr", {21'd0, sample_addr}, 32'd0);
      check("mid_rst_we", {31'd0, sample_we}, 32'd0);
      check("mid_rst_aline", {22'd0, aline_idx}, 32'd0);
      check("mid_rst_bank_sel", {31'd0, bank_sel}, 32'd0);
      check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      sclr = 1'b0;
      tick(2);
      push_aline(1'b0, 10'd0, 8);
      pulse_trig();
      tick(LINE_WAIT);
      check("post_rst_aline", {22'd0, aline_idx}, 32'd1);

`ifdef ACQ_TRIG_DELAY_EN
      // Dropping enable during DELAY returns to IDLE without writing
      pulse_trig();
      enable = 1'b0;
      tick(LINE_WAIT);
      check("delay_abort_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      tick(2);
`endif

      check("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
